// File: rtl/rf_pkg.sv
// rf_pkg: unit map and context-engine state type shared by rf_multiport_ctx.
package rf_pkg;
    localparam int UNIT_MAIN  = 0;
    localparam int UNIT_INST  = 1;
    localparam int UNIT_FLAGS = 2;
    localparam int UNIT_IP    = 3;
    localparam int GPR_BASE   = 4;
    typedef enum logic [1:0] {IDLE, SAVE, RESTORE, DONE} ctx_state_t;
endpackage

// File: rtl/rf_ctx_engine.sv
// rf_ctx_engine: save/restore sequencer walking GPR indices one per cycle.
module rf_ctx_engine
    import rf_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     save,
    input  logic                     restore,
    output logic                     busy,
    output logic                     done,
    output logic                     save_dir,
    output logic [ADDRESS_WIDTH-1:0] idx
);
    localparam logic [ADDRESS_WIDTH-1:0] LAST = '1;
    ctx_state_t state;
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            save_dir <= 1'b0;
            idx      <= ADDRESS_WIDTH'(GPR_BASE);
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    // save wins when both requests arrive together
                    if (save || restore) begin
                        state    <= save ? SAVE : RESTORE;
                        busy     <= 1'b1;
                        save_dir <= save;
                        idx      <= ADDRESS_WIDTH'(GPR_BASE);
                    end
                end
                SAVE, RESTORE: begin
                    if (idx == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/rf_multiport_ctx.sv
// rf_multiport_ctx: multi-port register file with IP, flags and shadow GPR bank.
// Optional same-cycle write-to-read bypass when RF_BYPASS_EN is defined.
module rf_multiport_ctx
    import rf_pkg::*;
#(
    parameter int WORD_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 4,
    parameter int READ_PORTS    = 8,
    parameter int WRITE_PORTS   = 4
) (
    input  logic                                     clk_i,
    input  logic                                     arst_ni,
    input  logic [READ_PORTS-1:0][ADDRESS_WIDTH-1:0] rd_sel_i,
    output logic [READ_PORTS-1:0][WORD_WIDTH-1:0]    rd_data_o,
    input  logic [WRITE_PORTS-1:0][ADDRESS_WIDTH-1:0] wr_sel_i,
    input  logic [WRITE_PORTS-1:0][WORD_WIDTH-1:0]    wr_data_i,
    input  logic [WRITE_PORTS-1:0]                    wr_en_i,
    input  logic [WORD_WIDTH-1:0]                     main_input_i,
    input  logic [WORD_WIDTH-1:0]                     inst_input_i,
    input  logic [WORD_WIDTH-1:0]                     flags_i,
    input  logic                                      ip_step_i,
    input  logic                                      ctx_save_i,
    input  logic                                      ctx_restore_i,
    output logic                                      ctx_busy_o,
    output logic                                      ctx_done_o,
    output logic [WORD_WIDTH-1:0]                     instr_ptr_o,
    output logic [WORD_WIDTH-1:0]                     flags_o
);
    localparam int UNITS = 2 ** ADDRESS_WIDTH;
    logic [WORD_WIDTH-1:0]    regs   [UNITS];
    logic [WORD_WIDTH-1:0]    shadow [UNITS];
    logic [WORD_WIDTH-1:0]    val    [UNITS];
    logic [UNITS-1:0]         hit;
    logic [UNITS-1:0]         wen;
    logic                     busy;
    logic                     save_dir;
    logic [ADDRESS_WIDTH-1:0] idx;
    rf_ctx_engine #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_engine (
        .clk      (clk_i),
        .arst_n   (arst_ni),
        .save     (ctx_save_i),
        .restore  (ctx_restore_i),
        .busy     (busy),
        .done     (ctx_done_o),
        .save_dir (save_dir),
        .idx      (idx)
    );
    assign ctx_busy_o  = busy;
    assign flags_o     = regs[UNIT_FLAGS];
    assign instr_ptr_o = regs[UNIT_IP];
    // later ports overwrite earlier ones, giving the highest index priority
    always_comb begin
        for (int u = 0; u < UNITS; u++) begin
            hit[u] = 1'b0;
            val[u] = '0;
            for (int p = 0; p < WRITE_PORTS; p++)
                if (wr_en_i[p] && wr_sel_i[p] == ADDRESS_WIDTH'(u)) begin
                    hit[u] = 1'b1;
                    val[u] = wr_data_i[p];
                end
            wen[u] = hit[u] && u >= UNIT_FLAGS && (u < GPR_BASE || !busy);
        end
    end
    always_comb begin
        for (int r = 0; r < READ_PORTS; r++) begin
            rd_data_o[r] = rd_sel_i[r] == ADDRESS_WIDTH'(UNIT_MAIN) ? main_input_i :
                           rd_sel_i[r] == ADDRESS_WIDTH'(UNIT_INST) ? inst_input_i : regs[rd_sel_i[r]];
`ifdef RF_BYPASS_EN
            if (wen[rd_sel_i[r]]) rd_data_o[r] = val[rd_sel_i[r]];
`endif
        end
    end
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            for (int u = 0; u < UNITS; u++) begin
                regs[u]   <= '0;
                shadow[u] <= '0;
            end
        end else begin
            regs[UNIT_FLAGS] <= wen[UNIT_FLAGS] ? val[UNIT_FLAGS] : flags_i;
            regs[UNIT_IP]    <= wen[UNIT_IP] ? val[UNIT_IP] :
                                ip_step_i ? regs[UNIT_IP] + 1'b1 : regs[UNIT_IP];
            for (int u = GPR_BASE; u < UNITS; u++)
                if (wen[u]) regs[u] <= val[u];
            // port writes to GPRs are blocked while busy, so the copy never collides
            if (busy && save_dir) shadow[idx] <= regs[idx];
            if (busy && !save_dir) regs[idx] <= shadow[idx];
        end
    end
endmodule

// File: tb/tb_rf_multiport_ctx.sv
// tb_rf_multiport_ctx: vector table plus scoreboarded sequences for rf_multiport_ctx.
module tb_rf_multiport_ctx;
    logic              clk = 1'b0;
    logic              arst_ni;
    logic [7:0][3:0]   rd_sel;
    logic [7:0][15:0]  rd_data;
    logic [3:0][3:0]   wr_sel;
    logic [3:0][15:0]  wr_data;
    logic [3:0]        wr_en;
    logic [15:0]       main_in, inst_in, flags_in, ip, flags;
    logic              ip_step, ctx_save, ctx_restore, busy, done;
    int                checks = 0;
    int                errors = 0;

    typedef struct { string name; logic [15:0] exp; } sb_t;
    typedef struct { string name; int port; logic [3:0] sel; logic [15:0] data; logic [3:0] rsel; logic [15:0] exp; } vec_t;
    sb_t  sb[$];
    vec_t vecs[7];

    rf_multiport_ctx dut (
        .clk_i(clk), .arst_ni(arst_ni), .rd_sel_i(rd_sel), .rd_data_o(rd_data),
        .wr_sel_i(wr_sel), .wr_data_i(wr_data), .wr_en_i(wr_en),
        .main_input_i(main_in), .inst_input_i(inst_in), .flags_i(flags_in),
        .ip_step_i(ip_step), .ctx_save_i(ctx_save), .ctx_restore_i(ctx_restore),
        .ctx_busy_o(busy), .ctx_done_o(done), .instr_ptr_o(ip), .flags_o(flags)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int p, input logic [3:0] s, input logic [15:0] d);
        wr_sel[p]  = s;
        wr_data[p] = d;
        wr_en[p]   = 1'b1;
    endtask

    task automatic expect_v(input string n, input logic [15:0] e);
        sb.push_back('{n, e});
    endtask

    task automatic check(input logic [15:0] act);
        sb_t t;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty actual=%h", act);
        end else begin
            t = sb.pop_front();
            if (act !== t.exp) begin
                errors++;
                $display("FAIL %s actual=%h expected=%h", t.name, act, t.exp);
            end
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (busy && n < 50) begin
            step();
            n++;
        end
        expect_v("ctx_done_pulse", 16'h1);
        check({15'b0, done});
    endtask

    initial begin
        vecs[0] = '{"gpr4_write",  0, 4'd4,  16'h1234, 4'd4,  16'h1234};
        vecs[1] = '{"gpr15_write", 2, 4'd15, 16'hA5A5, 4'd15, 16'hA5A5};
        vecs[2] = '{"inst_ro",     3, 4'd1,  16'h7777, 4'd1,  16'h0F0F};
        vecs[3] = '{"main_ro",     1, 4'd0,  16'h8888, 4'd0,  16'h00C3};
        vecs[4] = '{"ip_write",    1, 4'd3,  16'h0100, 4'd3,  16'h0100};
        vecs[5] = '{"gpr6_write",  0, 4'd6,  16'hFFFF, 4'd6,  16'hFFFF};
        vecs[6] = '{"flags_write", 2, 4'd2,  16'h00A5, 4'd2,  16'h00A5};
        arst_ni = 1'b0; rd_sel = '0; wr_sel = '0; wr_data = '0; wr_en = '0;
        main_in = 16'h00C3; inst_in = 16'h0F0F; flags_in = 16'h0055;
        ip_step = 1'b0; ctx_save = 1'b0; ctx_restore = 1'b0;
        rd_sel[0] = 4'd5;
        #2;
        expect_v("rst_ip", 16'h0);    check(ip);
        expect_v("rst_flags", 16'h0); check(flags);
        expect_v("rst_busy", 16'h0);  check({15'b0, busy});
        expect_v("rst_gpr5", 16'h0);  check(rd_data[0]);
        #10 arst_ni = 1'b1;
        step();
        expect_v("flags_follow_input", 16'h0055); check(flags);

        for (int i = 0; i < 7; i++) begin
            wr(vecs[i].port, vecs[i].sel, vecs[i].data);
            rd_sel[0] = vecs[i].rsel;
            expect_v(vecs[i].name, vecs[i].exp);
            step();
            wr_en = '0;
            check(rd_data[0]);
        end

        wr(0, 4'd5, 16'h1111); wr(3, 4'd5, 16'h3333); wr(1, 4'd1, 16'h7777);
        rd_sel[0] = 4'd5; rd_sel[1] = 4'd1;
        expect_v("prio_unit5", 16'h3333); expect_v("prio_inst", 16'h0F0F);
        step(); wr_en = '0;
        check(rd_data[0]); check(rd_data[1]);

        wr(0, 4'd3, 16'hFFFF); step(); wr_en = '0;
        ip_step = 1'b1; expect_v("ip_wrap", 16'h0000); step(); check(ip);
        wr(0, 4'd3, 16'h0040); expect_v("ip_write_beats_step", 16'h0040); step(); wr_en = '0; check(ip);
        expect_v("ip_step", 16'h0041); step(); check(ip);
        ip_step = 1'b0;

        for (int b = 0; b < 3; b++) begin
            for (int q = 0; q < 4; q++) wr(q, 4'(4 + 4 * b + q), 16'(16'h10 + 4 * b + q));
            step();
            wr_en = '0;
        end
        ctx_save = 1'b1; step(); ctx_save = 1'b0;
        begin
            int n = 0;
            while (busy && n < 50) begin
                if (n == 0) begin wr(0, 4'd7, 16'hDEAD); wr(1, 4'd2, 16'h00A5); end
                if (n == 1) ctx_restore = 1'b1;
                step();
                if (n == 0) begin expect_v("flags_during_busy", 16'h00A5); check(flags); end
                wr_en = '0; ctx_restore = 1'b0;
                n++;
            end
            expect_v("save_busy_cycles", 16'd12); check(16'(n));
        end
        expect_v("save_done", 16'h1); check({15'b0, done});
        rd_sel[0] = 4'd7;
        step();
        expect_v("done_one_cycle", 16'h0); check({15'b0, done});
        expect_v("restore_req_ignored", 16'h0); check({15'b0, busy});
        expect_v("gpr7_dropped", 16'h0013); check(rd_data[0]);

        for (int b = 0; b < 3; b++) begin
            for (int q = 0; q < 4; q++) wr(q, 4'(4 + 4 * b + q), 16'(16'hFF00 + 4 * b + q));
            step();
            wr_en = '0;
        end
        ctx_restore = 1'b1; step(); ctx_restore = 1'b0;
        wait_done();
        for (int r = 0; r < 8; r++) rd_sel[r] = 4'(4 + r);
        #1;
        for (int r = 0; r < 8; r++) begin expect_v("restore_lo", 16'(16'h10 + r)); check(rd_data[r]); end
        for (int r = 0; r < 4; r++) rd_sel[r] = 4'(12 + r);
        #1;
        for (int r = 0; r < 4; r++) begin expect_v("restore_hi", 16'(16'h18 + r)); check(rd_data[r]); end

        rd_sel[0] = 4'd9;
        wr(0, 4'd9, 16'hBEEF);
        #1;
`ifdef RF_BYPASS_EN
        expect_v("bypass_same_cycle", 16'hBEEF);
`else
        expect_v("no_bypass_same_cycle", 16'h0015);
`endif
        check(rd_data[0]);
        step(); wr_en = '0;
        expect_v("write_next_cycle", 16'hBEEF); check(rd_data[0]);

        ctx_save = 1'b1; step(); ctx_save = 1'b0;
        step(); step();
        #2 arst_ni = 1'b0;
        #1;
        expect_v("midsave_rst_busy", 16'h0); check({15'b0, busy});
        expect_v("midsave_rst_ip", 16'h0);   check(ip);
        expect_v("midsave_rst_flags", 16'h0); check(flags);
        #2 arst_ni = 1'b1;
        step();
        for (int b = 0; b < 2; b++) begin
            for (int q = 0; q < 4; q++) wr(q, 4'(4 + 4 * b + q), 16'(16'hAA00 + 4 * b + q));
            step();
            wr_en = '0;
        end
        ctx_restore = 1'b1; step(); ctx_restore = 1'b0;
        wait_done();
        for (int r = 0; r < 8; r++) rd_sel[r] = 4'(4 + r);
        #1;
        for (int r = 0; r < 8; r++) begin expect_v("shadow_cleared", 16'h0); check(rd_data[r]); end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
